// File: rtl/fft_butterfly_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fft_butterfly_seq
//
// Radix-2 DIT butterfly sequencer for one FFT stage. It takes one operand set
// (A, B, twiddle W) and computes B*W as four real products. Each product goes
// through a shared serial 8x9 signed multiplier, one at a time. It then emits
// (A+BW)/2 and (A-BW)/2, each saturated to 9 bits signed.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (transfer on in_valid & in_ready)
//   a_re, a_im            sample A, signed 8-bit
//   b_re, b_im            sample B, signed 8-bit
//   w_re, w_im            twiddle, signed Q1.7 in 9 bits (+128 = +1.0)
//   mult_start            one-cycle start pulse to the multiplier
//   mult_in_0, mult_in_1  B / W component presented to the multiplier
//   mult_valid, mult_out  multiplier done pulse and 17-bit signed product
//   y0_*, y1_*            results, signed 9-bit, held until the next result
//   out_valid             one-cycle pulse when new results are presented
// -----------------------------------------------------------------------------
module fft_butterfly_seq #(
  parameter int GUARD = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  a_re,
  input  logic signed [7:0]  a_im,
  input  logic signed [7:0]  b_re,
  input  logic signed [7:0]  b_im,
  input  logic signed [8:0]  w_re,
  input  logic signed [8:0]  w_im,
  output logic               mult_start,
  output logic signed [7:0]  mult_in_0,
  output logic signed [8:0]  mult_in_1,
  input  logic               mult_valid,
  input  logic signed [16:0] mult_out,
  output logic signed [8:0]  y0_re,
  output logic signed [8:0]  y0_im,
  output logic signed [8:0]  y1_re,
  output logic signed [8:0]  y1_im,
  output logic               out_valid
);

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMBINE,
    S_OUTPUT
  } state_t;

  state_t             state_q;
  logic [1:0]         k_q;
  logic [1:0]         k_d;
  logic [GW-1:0]      guard_q;
  logic [GW-1:0]      guard_d;
  logic               in_ready_q;
  logic               mult_start_q;
  logic               out_valid_q;
  logic signed [7:0]  mult_in_0_q;
  logic signed [8:0]  mult_in_1_q;
  logic signed [7:0]  a_re_q, a_im_q, b_re_q, b_im_q;
  logic signed [8:0]  w_re_q, w_im_q;
  logic signed [16:0] p_q [4];
  logic signed [8:0]  y0_re_q, y0_im_q, y1_re_q, y1_im_q;

  // Product order: k0 b_re*w_re, k1 b_im*w_im, k2 b_re*w_im, k3 b_im*w_re.
  function automatic logic signed [7:0] sel_b(input logic [1:0] k,
                                              input logic signed [7:0] re,
                                              input logic signed [7:0] im);
    sel_b = k[0] ? im : re;
  endfunction

  function automatic logic signed [8:0] sel_w(input logic [1:0] k,
                                              input logic signed [8:0] re,
                                              input logic signed [8:0] im);
    sel_w = (k[0] ^ k[1]) ? im : re;
  endfunction

  // Halve (arithmetic) then clamp to the 9-bit signed range [-256, 255].
  function automatic logic signed [8:0] half_sat(input logic signed [11:0] v);
    logic signed [11:0] h;
    h = v >>> 1;
    if (h > 12'sd255)
      half_sat = 9'h0FF;
    else if (h < $signed(12'hF00))
      half_sat = 9'h100;
    else
      half_sat = h[8:0];
  endfunction

  // The guard counter counts down once per cycle after reset. in_ready stays
  // low while it is nonzero. This keeps out a late data_valid from a multiply
  // abandoned by reset, because the multiplier itself is never reset.
  assign guard_d = (guard_q != '0) ? guard_q - GW'(1) : guard_q;
  assign k_d     = k_q + 2'd1;

  // Combine datapath, evaluated from the stored products during COMBINE
  logic signed [17:0] re_sum, im_sum;
  logic signed [10:0] t_c [2];
  logic signed [7:0]  a_c [2];
  logic signed [8:0]  y0_c [2];
  logic signed [8:0]  y1_c [2];

  assign re_sum = {p_q[0][16], p_q[0]} - {p_q[1][16], p_q[1]};
  assign im_sum = {p_q[2][16], p_q[2]} + {p_q[3][16], p_q[3]};
  // Dropping the 7 fractional twiddle bits is an arithmetic shift right by 7.
  assign t_c[0] = re_sum[17:7];
  assign t_c[1] = im_sum[17:7];
  assign a_c[0] = a_re_q;
  assign a_c[1] = a_im_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_comp
    logic signed [11:0] a_ext;
    logic signed [11:0] t_ext;
    assign a_ext    = {{4{a_c[gi][7]}}, a_c[gi]};
    assign t_ext    = {t_c[gi][10], t_c[gi]};
    assign y0_c[gi] = half_sat(a_ext + t_ext);
    assign y1_c[gi] = half_sat(a_ext - t_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      guard_q      <= GW'(GUARD);
      in_ready_q   <= 1'b0;
      mult_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      mult_in_0_q  <= '0;
      mult_in_1_q  <= '0;
      a_re_q       <= '0;
      a_im_q       <= '0;
      b_re_q       <= '0;
      b_im_q       <= '0;
      w_re_q       <= '0;
      w_im_q       <= '0;
      for (int i = 0; i < 4; i++) p_q[i] <= '0;
      y0_re_q      <= '0;
      y0_im_q      <= '0;
      y1_re_q      <= '0;
      y1_im_q      <= '0;
    end else begin
      guard_q      <= guard_d;
      mult_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_re_q       <= a_re;
            a_im_q       <= a_im;
            b_re_q       <= b_re;
            b_im_q       <= b_im;
            w_re_q       <= w_re;
            w_im_q       <= w_im;
            k_q          <= 2'd0;
            // Present the k0 operands straight from the inputs so the start
            // pulse can go out in the very next cycle.
            mult_in_0_q  <= b_re;
            mult_in_1_q  <= w_re;
            mult_start_q <= 1'b1;
            in_ready_q   <= 1'b0;
            state_q      <= S_ISSUE;
          end else begin
            in_ready_q <= (guard_d == '0);
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_valid) begin
            p_q[k_q] <= mult_out;
            if (k_q != 2'd3) begin
              k_q          <= k_d;
              mult_in_0_q  <= sel_b(k_d, b_re_q, b_im_q);
              mult_in_1_q  <= sel_w(k_d, w_re_q, w_im_q);
              mult_start_q <= 1'b1;
              state_q      <= S_ISSUE;
            end else begin
              state_q <= S_COMBINE;
            end
          end
        end
        S_COMBINE: begin
          y0_re_q     <= y0_c[0];
          y0_im_q     <= y0_c[1];
          y1_re_q     <= y1_c[0];
          y1_im_q     <= y1_c[1];
          out_valid_q <= 1'b1;
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          in_ready_q <= (guard_d == '0);
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mult_start = mult_start_q;
  assign mult_in_0  = mult_in_0_q;
  assign mult_in_1  = mult_in_1_q;
  assign out_valid  = out_valid_q;
  assign y0_re      = y0_re_q;
  assign y0_im      = y0_im_q;
  assign y1_re      = y1_re_q;
  assign y1_im      = y1_im_q;

endmodule

// File: tb/tb_fft_butterfly_seq.sv
`timescale 1ns/1ps
// Directed bench for fft_butterfly_seq with a behavioural serial multiplier
// (start -> data_valid 18 cycles later, no reset, like the real part).
module tb_fft_butterfly_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  a_re, a_im, b_re, b_im;
  logic signed [8:0]  w_re, w_im;
  logic               mult_start;
  logic signed [7:0]  mult_in_0;
  logic signed [8:0]  mult_in_1;
  logic               mult_valid;
  logic signed [16:0] mult_out;
  logic signed [8:0]  y0_re, y0_im, y1_re, y1_im;
  logic               out_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  fft_butterfly_seq #(.GUARD(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_re       (a_re),
    .a_im       (a_im),
    .b_re       (b_re),
    .b_im       (b_im),
    .w_re       (w_re),
    .w_im       (w_im),
    .mult_start (mult_start),
    .mult_in_0  (mult_in_0),
    .mult_in_1  (mult_in_1),
    .mult_valid (mult_valid),
    .mult_out   (mult_out),
    .y0_re      (y0_re),
    .y0_im      (y0_im),
    .y1_re      (y1_re),
    .y1_im      (y1_im),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model
  int                 mdl_cnt  = 0;
  logic signed [16:0] mdl_prod = '0;
  logic               stray_mv = 1'b0;

  always @(posedge clk) begin
    if (mult_start) begin
      mdl_cnt  <= 18;
      mdl_prod <= 17'(mult_in_0) * 17'(mult_in_1);
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end
  assign mult_valid = (mdl_cnt == 1) || stray_mv;
  assign mult_out   = mdl_prod;

  // Results of the most recent run_bf
  logic signed [8:0] r_y0re, r_y0im, r_y1re, r_y1im;
  int r_t, r_tabs, r_nstarts, r_busy_ready;
  int r_st [4];
  bit r_timeout;

  // Drives one butterfly and records its observable timeline relative to the
  // transfer cycle T. With scramble set, in_valid stays high and the operands
  // are changed right after the transfer.
  task automatic run_bf(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit scramble);
    int  n;
    int  rel;
    bit  done;
    r_timeout = 0; r_nstarts = 0; r_busy_ready = 0; r_t = -1; r_tabs = -1;
    for (int i = 0; i < 4; i++) r_st[i] = -1;
    @(negedge clk);
    a_re = 8'(ar); a_im = 8'(ai); b_re = 8'(br); b_im = 8'(bi);
    w_re = 9'(wr); w_im = 9'(wi);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      r_timeout = 1;
      in_valid  = 1'b0;
      $display("bf a=(%0d,%0d) no transfer within 200 cycles", ar, ai);
      return;
    end
    r_tabs = cyc;
    done = 0;
    for (int i = 0; i < 150 && !done; i++) begin
      @(negedge clk);
      rel = cyc - r_tabs;
      if (rel == 1) begin
        if (scramble) begin
          a_re = 8'sd99; a_im = -8'sd99; b_re = -8'sd77; b_im = 8'sd55;
          w_re = 9'sd33; w_im = -9'sd100;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (mult_start) begin
        if (r_nstarts < 4) r_st[r_nstarts] = rel;
        r_nstarts++;
      end
      if (in_ready) r_busy_ready++;
      if (out_valid) begin
        r_y0re = y0_re; r_y0im = y0_im; r_y1re = y1_re; r_y1im = y1_im;
        r_t  = rel;
        done = 1;
      end
    end
    if (!done) r_timeout = 1;
    $display("bf a=(%0d,%0d) b=(%0d,%0d) w=(%0d,%0d) T=%0d lat=%0d y0=(%0d,%0d) y1=(%0d,%0d)",
             ar, ai, br, bi, wr, wi, r_tabs, r_t, r_y0re, r_y0im, r_y1re, r_y1im);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; in_valid = 1'b0; stray_mv = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
    total_cnt++;
    if (mult_start !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rst_pulses: got start=%0b out_valid=%0b expected 0/0", mult_start, out_valid);
    else pass_cnt++;
    total_cnt++;
    if ({y0_re, y0_im, y1_re, y1_im} !== 36'd0)
      $display("FAIL rst_results: got %h expected 0", {y0_re, y0_im, y1_re, y1_im});
    else pass_cnt++;
    rst_n = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n !== 20) $display("FAIL rst_guard_len: got %0d expected 20", n); else pass_cnt++;
    $display("reset released, in_ready after %0d cycles", n);
  endtask

  task automatic test_identity();
    run_bf(10, -4, 20, 6, 128, 0, 1'b0);
    total_cnt++;
    if (r_timeout !== 1'b0) $display("FAIL t1_timeout: got 1 expected 0"); else pass_cnt++;
    total_cnt++;
    if (r_nstarts !== 4) $display("FAIL t1_nstarts: got %0d expected 4", r_nstarts); else pass_cnt++;
    total_cnt++;
    if (r_st[0] !== 1 || r_st[1] !== 20 || r_st[2] !== 39 || r_st[3] !== 58)
      $display("FAIL t1_start_times: got %0d,%0d,%0d,%0d expected 1,20,39,58",
               r_st[0], r_st[1], r_st[2], r_st[3]);
    else pass_cnt++;
    total_cnt++;
    if (r_t !== 78) $display("FAIL t1_latency: got %0d expected 78", r_t); else pass_cnt++;
    total_cnt++;
    if (r_y0re !== 9'(15)) $display("FAIL t1_y0_re: got %0d expected 15", r_y0re); else pass_cnt++;
    total_cnt++;
    if (r_y0im !== 9'(1)) $display("FAIL t1_y0_im: got %0d expected 1", r_y0im); else pass_cnt++;
    total_cnt++;
    if (r_y1re !== 9'(-5)) $display("FAIL t1_y1_re: got %0d expected -5", r_y1re); else pass_cnt++;
    total_cnt++;
    if (r_y1im !== 9'(-5)) $display("FAIL t1_y1_im: got %0d expected -5", r_y1im); else pass_cnt++;
    total_cnt++;
    if (r_busy_ready !== 0) $display("FAIL t1_busy_ready: got %0d high cycles expected 0", r_busy_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL t1_after: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (y0_re !== 9'(15)) $display("FAIL t1_hold: got %0d expected 15", y0_re); else pass_cnt++;
  endtask

  task automatic test_neg_j();
    run_bf(0, 0, 64, 0, 0, -128, 1'b0);
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(0), 9'(-32), 9'(0), 9'(32)})
      $display("FAIL negj_results: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(0,-32) y1=(0,32)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    run_bf(127, 127, 127, 127, -256, -256, 1'b0);
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(63), 9'(-191), 9'(63), 9'(255)})
      $display("FAIL sat_pos: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(63,-191) y1=(63,255)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
    run_bf(-128, -128, -128, -128, -256, 0, 1'b0);
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(64), 9'(64), 9'(-192), 9'(-192)})
      $display("FAIL sat_edge: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(64,64) y1=(-192,-192)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
    run_bf(-128, -128, -128, -128, -256, 255, 1'b0);
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(191), 9'(-64), 9'(-256), 9'(-65)})
      $display("FAIL sat_neg: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(191,-64) y1=(-256,-65)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t_first;
    run_bf(10, -4, 20, 6, 128, 0, 1'b1);
    t_first = r_tabs;
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(15), 9'(1), 9'(-5), 9'(-5)})
      $display("FAIL b2b_first: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(15,1) y1=(-5,-5)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
    total_cnt++;
    if (r_busy_ready !== 0) $display("FAIL b2b_busy_ready: got %0d high cycles expected 0", r_busy_ready); else pass_cnt++;
    run_bf(0, 0, 64, 0, 0, -128, 1'b0);
    total_cnt++;
    if (r_tabs - t_first !== 79)
      $display("FAIL b2b_interval: got %0d expected 79", r_tabs - t_first);
    else pass_cnt++;
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(0), 9'(-32), 9'(0), 9'(32)})
      $display("FAIL b2b_second: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(0,-32) y1=(0,32)",
               r_y0re, r_y0im, r_y1re, r_y1im);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int n, nov, nst, t0;
    @(negedge clk);
    a_re = 8'sd10; a_im = -8'sd4; b_re = 8'sd20; b_im = 8'sd6; w_re = 9'sd128; w_im = 9'sd0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc - t0 < 40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0 || mult_start !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midrst_ctrl: got ready=%0b start=%0b valid=%0b expected 0/0/0",
               in_ready, mult_start, out_valid);
    else pass_cnt++;
    total_cnt++;
    if ({y0_re, y0_im, y1_re, y1_im} !== 36'd0)
      $display("FAIL midrst_results: got %h expected 0", {y0_re, y0_im, y1_re, y1_im});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; nov = 0; nst = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) nov++;
      if (mult_start) nst++;
    end
    total_cnt++;
    if (n !== 20) $display("FAIL midrst_guard: got %0d expected 20", n); else pass_cnt++;
    total_cnt++;
    if (nov !== 0 || nst !== 0)
      $display("FAIL midrst_stray: got out_valid=%0d starts=%0d expected 0/0", nov, nst);
    else pass_cnt++;
    $display("mid-op reset at T+40, guard %0d cycles", n);
    run_bf(10, -4, 20, 6, 128, 0, 1'b0);
    total_cnt++;
    if ({r_y0re, r_y0im, r_y1re, r_y1im} !== {9'(15), 9'(1), 9'(-5), 9'(-5)} || r_t !== 78)
      $display("FAIL midrst_next: got y0=(%0d,%0d) y1=(%0d,%0d) lat=%0d expected y0=(15,1) y1=(-5,-5) lat=78",
               r_y0re, r_y0im, r_y1re, r_y1im, r_t);
    else pass_cnt++;
  endtask

  task automatic test_idle_mult_valid();
    int nov, nst, nrdy;
    @(negedge clk);
    stray_mv = 1'b1;
    @(negedge clk);
    stray_mv = 1'b0;
    nov = 0; nst = 0; nrdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) nov++;
      if (mult_start) nst++;
      if (in_ready) nrdy++;
    end
    $display("idle mult_valid pulse injected");
    total_cnt++;
    if (nov !== 0 || nst !== 0)
      $display("FAIL idle_mv_pulses: got out_valid=%0d starts=%0d expected 0/0", nov, nst);
    else pass_cnt++;
    total_cnt++;
    if (nrdy !== 6) $display("FAIL idle_mv_ready: got %0d ready cycles expected 6", nrdy); else pass_cnt++;
    total_cnt++;
    if ({y0_re, y0_im, y1_re, y1_im} !== {9'(15), 9'(1), 9'(-5), 9'(-5)})
      $display("FAIL idle_mv_hold: got y0=(%0d,%0d) y1=(%0d,%0d) expected y0=(15,1) y1=(-5,-5)",
               y0_re, y0_im, y1_re, y1_im);
    else pass_cnt++;
    run_bf(0, 0, 64, 0, 0, -128, 1'b0);
    total_cnt++;
    if (r_y0im !== 9'(-32) || r_t !== 78)
      $display("FAIL idle_mv_next: got y0_im=%0d lat=%0d expected -32/78", r_y0im, r_t);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    test_reset();
    test_identity();
    test_neg_j();
    test_saturation();
    test_back_to_back();
    test_reset_mid_op();
    test_idle_mult_valid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_butterfly_seq.md
# fft_butterfly_seq

Radix-2 decimation-in-time butterfly sequencer for one FFT stage. Accepts one butterfly operand set (samples A, B and twiddle W), computes B·W with four real products issued one at a time through the shared serial 8×9-bit signed multiplier (`multiplier_8_9Bit`), then forms the scaled, saturated outputs (A+BW)/2 and (A−BW)/2. Sits directly around the multiplier: it is the multiplier's only driver and only consumer, and it feeds the stage's output buffer.

## Interface
- `GUARD`, 20: cycles after reset release during which `in_ready` is held low.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block idle and guard expired; transfer on `in_valid & in_ready`.
- `a_re`, `a_im`  in  8 each  sample A, signed.
- `b_re`, `b_im`  in  8 each  sample B, signed.
- `w_re`, `w_im`  in  9 each  twiddle, signed Q1.7 (+128 = +1.0).
- `mult_start`  out  1  one-cycle start pulse to multiplier.
- `mult_in_0`  out  8  B component to multiplier.
- `mult_in_1`  out  9  W component to multiplier.
- `mult_valid`  in  1  multiplier `data_valid` (one-cycle pulse).
- `mult_out`  in  17  multiplier product, signed.
- `y0_re`, `y0_im`, `y1_re`, `y1_im`  out  9 each  results, signed.
- `out_valid`  out  1  one-cycle pulse, results valid that cycle and held until next result.

## Operation
- States: IDLE, ISSUE, WAIT, COMBINE, OUTPUT. Product index k = 0..3.
- IDLE: `in_ready`=1 (after guard). On transfer, register all six operands, k=0, go ISSUE.
- ISSUE: `mult_start`=1 for exactly one cycle; `mult_in_0`/`mult_in_1` = operands for k (k0: b_re·w_re, k1: b_im·w_im, k2: b_re·w_im, k3: b_im·w_re); go WAIT. Operands held stable in WAIT.
- WAIT: on `mult_valid`, store `mult_out` in p[k]; if k<3, k+1 and go ISSUE; else go COMBINE. `mult_valid` in any other state is ignored.
- COMBINE: re = p0 − p1, im = p2 + p3 (18-bit signed); t = value >>> 7 (arithmetic, 11-bit). go OUTPUT.
- OUTPUT: y0 = (a + t) >>> 1, y1 = (a − t) >>> 1, computed in 12 bits, per component; saturate to [−256, 255]. Register outputs, `out_valid`=1 one cycle, go IDLE.
- `mult_start` never high outside ISSUE; never high two consecutive cycles (multiplier retriggers on held start).
- Reset (any time, incl. mid-operation): state IDLE, k=0, guard counter reloaded to GUARD, all outputs 0 (`in_ready`=0, `mult_start`=0, `out_valid`=0, results 0). Guard covers a stray `data_valid` from an abandoned multiply (multiplier has no reset).

## Timing
- Transfer in cycle T; `mult_start` for k0 in T+1.
- Multiplier latency: `mult_valid` 18 cycles after its start cycle; next `mult_start` the cycle after `mult_valid`. Per product 19 cycles.
- Fourth `mult_valid` at T+76; COMBINE T+77; `out_valid` T+78. `in_ready` high again T+79. Throughput one butterfly per 79 cycles.
- `in_ready` low from reset release until GUARD cycles elapsed.
- Latency is handshake-driven: a slower multiplier lengthens WAIT without functional change.

## Test plan
- Reset then a=(10,−4), b=(20,6), w=(128,0) -> after guard, four start pulses 19 cycles apart; y0=(15,1), y1=(−5,−5), `out_valid` at T+78.
- a=(0,0), b=(64,0), w=(0,−128) (−j) -> y0=(0,−32), y1=(0,32).
- a=(127,127), b=(127,127), w=(−256,−256) -> t=(0,−508); y0=(63,−191), y1=(63,255) saturated; also b=(−128,−128), w=(−256,0) -> t=(256,256), y0 re=(−128+256)>>>1=64 checked; a−t saturation via a=(−128,·) giving −192 unsaturated, force extreme to hit −256 clamp.
- `in_valid` held high across busy period -> exactly one transfer per 79 cycles, `in_ready` low while busy, no operand change mid-op despite input changes.
- Assert `rst_n` low at T+40 mid-WAIT, release -> outputs 0 immediately, stray `mult_valid` at original schedule ignored, `in_ready` low GUARD cycles, next butterfly correct.
- Inject `mult_valid` pulse while IDLE -> no state change, no `out_valid`.
